// File: rtl/char_flow_arbiter.sv
// Merges a capital-letter and a lowercase character source into one stream
// through a one-entry output buffer; winner picked by starvation, then hint, then round-robin.
module char_flow_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_req,
  input  logic [WIDTH-1:0] cap_char,
  output logic             cap_ack,
  input  logic             low_req,
  input  logic [WIDTH-1:0] low_char,
  output logic             low_ack,
  input  logic             hint_en,
  input  logic             want_cap,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_char,
  output logic             out_src,
  input  logic             out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state, state_nx;
  logic [3:0] cap_cnt, low_cnt;
  logic       last_src;
  logic       load, cap_win, cap_starve, low_starve;

  assign cap_starve = (cap_cnt == 4'(MAX_WAIT));
  assign low_starve = (low_cnt == 4'(MAX_WAIT));
  assign out_valid  = (state == FULL);

  always_comb begin
    cap_win = 1'b0;
    if (cap_req && !low_req)         cap_win = 1'b1;
    else if (!cap_req && low_req)    cap_win = 1'b0;
    else if (cap_starve != low_starve) cap_win = cap_starve;
    else if (hint_en)                cap_win = want_cap;
    else                             cap_win = ~last_src;
  end

  // Acks are suppressed during reset so nothing is consumed that reset would discard.
  always_comb begin
    load     = !rst && ((state == EMPTY) || out_ready) && (cap_req || low_req);
    cap_ack  = load && cap_win;
    low_ack  = load && !cap_win;
    state_nx = state;
    case (state)
      EMPTY:   if (load) state_nx = FULL;
      FULL:    if (out_ready) state_nx = load ? FULL : EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_char <= '0;
      out_src  <= 1'b0;
      last_src <= 1'b0;
      cap_cnt  <= '0;
      low_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        out_char <= cap_win ? cap_char : low_char;
        out_src  <= cap_win;
        last_src <= cap_win;
      end
      if (!cap_req || cap_ack)       cap_cnt <= '0;
      else if (!cap_starve)          cap_cnt <= cap_cnt + 4'd1;
      if (!low_req || low_ack)       low_cnt <= '0;
      else if (!low_starve)          low_cnt <= low_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_char_flow_arbiter.sv
// Directed vector table plus a hand-written starvation sequence for char_flow_arbiter.
module tb_char_flow_arbiter;

  logic       clk = 1'b0;
  logic       rst, cap_req, low_req, hint_en, want_cap, out_ready;
  logic [7:0] cap_char, low_char, out_char;
  logic       cap_ack, low_ack, out_valid, out_src;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  char_flow_arbiter #(.WIDTH(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cap_req(cap_req), .cap_char(cap_char), .cap_ack(cap_ack),
    .low_req(low_req), .low_char(low_char), .low_ack(low_ack),
    .hint_en(hint_en), .want_cap(want_cap),
    .out_valid(out_valid), .out_char(out_char), .out_src(out_src),
    .out_ready(out_ready)
  );

  typedef struct {
    logic       rst, cr;
    logic [7:0] cc;
    logic       lr;
    logic [7:0] lc;
    logic       he, wc, rdy;
    logic       eca, ela, ev;
    logic [7:0] ec;
    logic       es, cd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, cr, input logic [7:0] cc, input logic lr,
                     input logic [7:0] lc, input logic he, wc, rdy,
                     input logic eca, ela, ev, input logic [7:0] ec, input logic es, cd);
    vec_t v;
    v.rst = r; v.cr = cr; v.cc = cc; v.lr = lr; v.lc = lc; v.he = he; v.wc = wc;
    v.rdy = rdy; v.eca = eca; v.ela = ela; v.ev = ev; v.ec = ec; v.es = es; v.cd = cd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, cr, input logic [7:0] cc, input logic lr,
                       input logic [7:0] lc, input logic he, wc, rdy);
    rst = r; cap_req = cr; cap_char = cc; low_req = lr; low_char = lc;
    hint_en = he; want_cap = wc; out_ready = rdy;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    // rst cr cc lr lc he wc rdy | cap_ack low_ack | ov oc os chk_data
    add(1, 1, "X", 0, 0,   0, 0, 1,  0, 0,  0, 0,   0, 1); // acks blocked in reset
    add(1, 0, 0,   0, 0,   0, 0, 1,  0, 0,  0, 0,   0, 1);
    add(0, 1, "I", 0, 0,   0, 0, 1,  1, 0,  1, "I", 1, 1); // first load, latency 1
    add(0, 1, "A", 1, "a", 0, 0, 1,  0, 1,  1, "a", 0, 1); // round-robin, no bubbles
    add(0, 1, "A", 1, "a", 0, 0, 1,  1, 0,  1, "A", 1, 1);
    add(0, 1, "A", 1, "a", 0, 0, 1,  0, 1,  1, "a", 0, 1);
    add(0, 1, "A", 1, "a", 0, 0, 1,  1, 0,  1, "A", 1, 1);
    add(0, 0, 0,   0, 0,   0, 0, 1,  0, 0,  0, 0,   0, 0); // drain to EMPTY
    add(0, 1, "C", 1, "l", 1, 0, 1,  0, 1,  1, "l", 0, 1); // hint favours low
    add(0, 1, "C", 1, "l", 1, 0, 1,  0, 1,  1, "l", 0, 1);
    add(0, 1, "C", 1, "l", 1, 0, 1,  0, 1,  1, "l", 0, 1);
    add(0, 1, "C", 1, "l", 1, 0, 1,  0, 1,  1, "l", 0, 1);
    add(0, 1, "C", 1, "l", 1, 0, 1,  1, 0,  1, "C", 1, 1); // cap starved
    add(0, 1, "C", 1, "l", 1, 0, 1,  0, 1,  1, "l", 0, 1);
    add(0, 1, "L", 0, 0,   0, 0, 1,  1, 0,  1, "L", 1, 1); // drain+load same cycle
    add(0, 1, "M", 1, "m", 0, 0, 0,  0, 0,  1, "L", 1, 1); // backpressure hold
    add(0, 1, "M", 1, "m", 0, 0, 0,  0, 0,  1, "L", 1, 1);
    add(0, 1, "M", 1, "m", 0, 0, 0,  0, 0,  1, "L", 1, 1);
    add(0, 1, "M", 1, "m", 0, 0, 1,  0, 1,  1, "m", 0, 1); // counters 3, rr -> low
    add(0, 0, 0,   0, 0,   0, 0, 1,  0, 0,  0, 0,   0, 0);
    add(0, 1, "I", 1, "o", 1, 1, 0,  1, 0,  1, "I", 1, 1); // EMPTY loads despite !ready
    add(0, 0, 0,   1, "o", 1, 0, 1,  0, 1,  1, "o", 0, 1);
    add(0, 0, 0,   1, "v", 1, 0, 1,  0, 1,  1, "v", 0, 1);
    add(0, 0, 0,   1, "e", 1, 0, 1,  0, 1,  1, "e", 0, 1);
    add(0, 0, 0,   0, 0,   0, 0, 1,  0, 0,  0, 0,   0, 0);
    add(0, 1, "Y", 0, 0,   0, 0, 0,  1, 0,  1, "Y", 1, 1);
    add(0, 0, 0,   1, "q", 0, 0, 0,  0, 0,  1, "Y", 1, 1); // low waits behind full buffer
    add(1, 1, "Z", 1, "q", 0, 0, 1,  0, 0,  0, 0,   0, 1); // reset discards "Y"
    add(0, 0, 0,   0, 0,   0, 0, 0,  0, 0,  0, 0,   0, 1);
    add(0, 1, "P", 1, "p", 0, 0, 1,  1, 0,  1, "P", 1, 1); // last_src reset -> cap first

    @(posedge clk); #1;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].cr, vq[i].cc, vq[i].lr, vq[i].lc, vq[i].he, vq[i].wc, vq[i].rdy);
      @(negedge clk);
      chk("cap_ack", i, {7'd0, cap_ack}, {7'd0, vq[i].eca});
      chk("low_ack", i, {7'd0, low_ack}, {7'd0, vq[i].ela});
      @(posedge clk); #1;
      chk("out_valid", i, {7'd0, out_valid}, {7'd0, vq[i].ev});
      if (vq[i].cd) begin
        chk("out_char", i, out_char, vq[i].ec);
        chk("out_src", i, {7'd0, out_src}, {7'd0, vq[i].es});
      end
    end

    // Low-side starvation: hint keeps picking cap until low's counter saturates.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      logic exp_cap;
      exp_cap = (k != 4);
      drive(0, 1, "S", 1, "s", 1, 1, 1);
      @(negedge clk);
      chk("starve_cap_ack", 100 + k, {7'd0, cap_ack}, {7'd0, exp_cap});
      chk("starve_low_ack", 100 + k, {7'd0, low_ack}, {7'd0, ~exp_cap});
      @(posedge clk); #1;
      chk("starve_valid", 100 + k, {7'd0, out_valid}, 8'd1);
      chk("starve_char", 100 + k, out_char, exp_cap ? 8'h53 : 8'h73);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
